// File: rtl/mem_stage.sv
// MIPS MEM stage: req/ack data-memory access with timeout, registered MEM/WB outputs.
// Optional alignment check enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       M_control,
    input  logic [1:0]       WB_control_in,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] store_data,
    input  logic [4:0]       dest_in,
    output logic             stall,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             wb_valid,
    output logic [1:0]       WB_control,
    output logic [WIDTH-1:0] ALU_out,
    output logic [WIDTH-1:0] Mem_out,
    output logic [4:0]       dest_out,
    output logic             mem_err,
    output logic             misalign
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state_reg;
    logic [7:0]       cnt_reg;
    logic             req_reg;
    logic             we_reg;
    logic [WIDTH-1:0] addr_reg;
    logic [WIDTH-1:0] wdata_reg;
    logic             load_reg;
    logic [1:0]       wbc_pend_reg;
    logic [4:0]       dest_pend_reg;
    logic             wb_valid_reg;
    logic [1:0]       wb_control_reg;
    logic [WIDTH-1:0] alu_out_reg;
    logic [WIDTH-1:0] mem_out_reg;
    logic [4:0]       dest_out_reg;
    logic             mem_err_reg;
    logic             misalign_reg;

    logic             misaligned;
    logic             timeout_hit;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = |alu_result[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // Fires on the cycle whose closing edge would be the TIMEOUT_CYCLES-th request cycle.
    assign timeout_hit = ({1'b0, cnt_reg} + 9'd1) >= 9'(TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 8'd0;
            req_reg        <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            load_reg       <= 1'b0;
            wbc_pend_reg   <= 2'b00;
            dest_pend_reg  <= 5'd0;
            wb_valid_reg   <= 1'b0;
            wb_control_reg <= 2'b00;
            alu_out_reg    <= '0;
            mem_out_reg    <= '0;
            dest_out_reg   <= 5'd0;
            mem_err_reg    <= 1'b0;
            misalign_reg   <= 1'b0;
        end else begin
            wb_valid_reg   <= 1'b0;
            wb_control_reg <= 2'b00;
            misalign_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        if (M_control == 2'b00) begin
                            wb_valid_reg   <= 1'b1;
                            wb_control_reg <= WB_control_in;
                            alu_out_reg    <= alu_result;
                            mem_out_reg    <= '0;
                            dest_out_reg   <= dest_in;
                        end else if (misaligned) begin
                            wb_valid_reg   <= 1'b1;
                            alu_out_reg    <= alu_result;
                            mem_out_reg    <= '0;
                            dest_out_reg   <= dest_in;
                            misalign_reg   <= 1'b1;
                        end else begin
                            state_reg     <= WAIT;
                            cnt_reg       <= 8'd0;
                            req_reg       <= 1'b1;
                            we_reg        <= M_control[0];
                            addr_reg      <= alu_result;
                            wdata_reg     <= store_data;
                            load_reg      <= (M_control == 2'b10);
                            wbc_pend_reg  <= WB_control_in;
                            dest_pend_reg <= dest_in;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg != 8'hFF) begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                    // Ack takes priority over a coincident timeout.
                    if (dmem_ack) begin
                        state_reg      <= IDLE;
                        req_reg        <= 1'b0;
                        wb_valid_reg   <= 1'b1;
                        wb_control_reg <= wbc_pend_reg;
                        alu_out_reg    <= addr_reg;
                        mem_out_reg    <= load_reg ? dmem_rdata : '0;
                        dest_out_reg   <= dest_pend_reg;
                    end else if (timeout_hit) begin
                        state_reg      <= IDLE;
                        req_reg        <= 1'b0;
                        mem_err_reg    <= 1'b1;
                        wb_valid_reg   <= 1'b1;
                        alu_out_reg    <= addr_reg;
                        mem_out_reg    <= '0;
                        dest_out_reg   <= dest_pend_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign stall      = (state_reg == WAIT);
    assign dmem_req   = req_reg;
    assign dmem_we    = we_reg;
    assign dmem_addr  = addr_reg;
    assign dmem_wdata = wdata_reg;
    assign wb_valid   = wb_valid_reg;
    assign WB_control = wb_control_reg;
    assign ALU_out    = alu_out_reg;
    assign Mem_out    = mem_out_reg;
    assign dest_out   = dest_out_reg;
    assign mem_err    = mem_err_reg;
    assign misalign   = misalign_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized transactions
// checked against a transaction-level model of latency, retirement and error flags.
module tb_mem_stage;
    localparam int WIDTH = 32;
    localparam int TO    = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [1:0]       M_control;
    logic [1:0]       WB_control_in;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] store_data;
    logic [4:0]       dest_in;
    logic             stall;
    logic             dmem_req;
    logic             dmem_we;
    logic [WIDTH-1:0] dmem_addr;
    logic [WIDTH-1:0] dmem_wdata;
    logic             dmem_ack;
    logic [WIDTH-1:0] dmem_rdata;
    logic             wb_valid;
    logic [1:0]       WB_control;
    logic [WIDTH-1:0] ALU_out;
    logic [WIDTH-1:0] Mem_out;
    logic [4:0]       dest_out;
    logic             mem_err;
    logic             misalign;

    int errors = 0;
    int checks = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    mem_stage #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .M_control(M_control),
        .WB_control_in(WB_control_in), .alu_result(alu_result), .store_data(store_data),
        .dest_in(dest_in), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .WB_control(WB_control),
        .ALU_out(ALU_out), .Mem_out(Mem_out), .dest_out(dest_out), .mem_err(mem_err),
        .misalign(misalign)
    );

    // One transaction: issue, serve memory with an ack after ack_after request
    // cycles (0 = never), then check the retirement against the model.
    task automatic do_txn(input logic [1:0] mc, input logic [1:0] wbc,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] dst, input int ack_after,
                          input logic [31:0] rd);
        bit memop, is_load, mis, tmo, done;
        logic [1:0]  e_wbc;
        logic [31:0] e_mem;
        int n;
        memop   = (mc != 2'b00);
        is_load = (mc == 2'b10);
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = memop && (addr[1:0] != 2'b00);
`endif
        tmo = memop && !mis && (ack_after == 0 || ack_after > TO);
        @(negedge clk);
        in_valid = 1'b1; M_control = mc; WB_control_in = wbc;
        alu_result = addr; store_data = wd; dest_in = dst;
        dmem_ack = memop ? 1'b0 : 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        @(posedge clk); #1;
        in_valid = 1'b0; dmem_ack = 1'b0;
        M_control = 2'($urandom); alu_result = $urandom;
        if (memop && !mis) begin
            n = 1; done = 1'b0;
            while (!done) begin
                checks++;
                if (stall !== 1'b1 || dmem_req !== 1'b1 || dmem_we !== mc[0] ||
                    dmem_addr !== addr || dmem_wdata !== wd) begin
                    errors++;
                    $display("FAIL req_phase cyc=%0d got stall=%b req=%b we=%b addr=%h wd=%h want 1 1 %b %h %h",
                             n, stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, mc[0], addr, wd);
                end
                if (n == ack_after) begin
                    dmem_ack = 1'b1; dmem_rdata = rd;
                end
                @(posedge clk); #1;
                dmem_ack = 1'b0; dmem_rdata = $urandom;
                if (n == ack_after || n == TO || n > 300) done = 1'b1;
                n++;
            end
        end
        if (tmo) exp_err = 1'b1;
        e_wbc = (tmo || mis) ? 2'b00 : wbc;
        e_mem = (is_load && !tmo && !mis) ? rd : 32'h0;
        checks++;
        if (wb_valid !== 1'b1 || WB_control !== e_wbc || ALU_out !== addr ||
            dest_out !== dst || stall !== 1'b0 || dmem_req !== 1'b0 ||
            mem_err !== exp_err || misalign !== mis || (!tmo && Mem_out !== e_mem)) begin
            errors++;
            $display("FAIL retire mc=%b got v=%b wbc=%b alu=%h mem=%h dst=%0d st=%b req=%b err=%b mis=%b want 1 %b %h %h %0d 0 0 %b %b",
                     mc, wb_valid, WB_control, ALU_out, Mem_out, dest_out, stall, dmem_req,
                     mem_err, misalign, e_wbc, addr, e_mem, dst, exp_err, mis);
        end
        @(posedge clk); #1;
        checks++;
        if (wb_valid !== 1'b0 || WB_control !== 2'b00 || misalign !== 1'b0 || ALU_out !== addr) begin
            errors++;
            $display("FAIL bubble got v=%b wbc=%b mis=%b alu=%h want 0 00 0 %h",
                     wb_valid, WB_control, misalign, ALU_out, addr);
        end
        $display("txn mc=%b addr=%h ack_after=%0d tmo=%0b mis=%0b", mc, addr, ack_after, tmo, mis);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; M_control = 2'b00; WB_control_in = 2'b00;
        alu_result = '0; store_data = '0; dest_in = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_err = 1'b0;
        checks++;
        if (stall !== 0 || dmem_req !== 0 || dmem_we !== 0 || wb_valid !== 0 || mem_err !== 0 ||
            misalign !== 0 || WB_control !== 0 || dmem_addr !== 0 || dmem_wdata !== 0 ||
            ALU_out !== 0 || Mem_out !== 0 || dest_out !== 0) begin
            errors++;
            $display("FAIL reset_state got st=%b req=%b we=%b v=%b err=%b mis=%b wbc=%b addr=%h wd=%h alu=%h mem=%h dst=%0d want all 0",
                     stall, dmem_req, dmem_we, wb_valid, mem_err, misalign, WB_control,
                     dmem_addr, dmem_wdata, ALU_out, Mem_out, dest_out);
        end
        $display("txn reset");
    endtask

    task automatic test_directed();
        do_txn(2'b00, 2'b10, 32'h1234, 32'h0, 5'd3, 0, 32'h0);
        do_txn(2'b10, 2'b11, 32'h40, 32'h0, 5'd4, 3, 32'hDEADBEEF);
        do_txn(2'b01, 2'b00, 32'h44, 32'hCAFE, 5'd0, 1, 32'h0);
        do_txn(2'b11, 2'b00, 32'h48, 32'hBEEF, 5'd0, 2, 32'h0);
        do_txn(2'b10, 2'b11, 32'h4C, 32'h0, 5'd5, TO, 32'h13572468);
    endtask

    task automatic test_timeout();
        do_txn(2'b10, 2'b11, 32'h80, 32'h0, 5'd6, 0, 32'h0);
        do_txn(2'b00, 2'b10, 32'h5555, 32'h0, 5'd7, 0, 32'h0);
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        in_valid = 1'b1; M_control = 2'b10; WB_control_in = 2'b11; alu_result = 32'h60; dest_in = 5'd9;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        exp_err = 1'b0;
        checks++;
        if (dmem_req !== 0 || stall !== 0 || wb_valid !== 0 || mem_err !== 0) begin
            errors++;
            $display("FAIL reset_in_wait got req=%b st=%b v=%b err=%b want 0 0 0 0",
                     dmem_req, stall, wb_valid, mem_err);
        end
        @(posedge clk); #1;
        checks++;
        if (wb_valid !== 0 || stall !== 0) begin
            errors++;
            $display("FAIL reset_in_wait_after got v=%b st=%b want 0 0", wb_valid, stall);
        end
        $display("txn reset_in_wait");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [4];
        logic [4:0]  d [4];
        for (int i = 0; i < 4; i++) begin
            a[i] = $urandom; d[i] = 5'($urandom);
        end
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (wb_valid !== 1 || ALU_out !== a[i-1] || dest_out !== d[i-1] ||
                    WB_control !== 2'b10 || Mem_out !== 0 || stall !== 0) begin
                    errors++;
                    $display("FAIL back_to_back i=%0d got v=%b alu=%h dst=%0d wbc=%b want 1 %h %0d 10",
                             i, wb_valid, ALU_out, dest_out, WB_control, a[i-1], d[i-1]);
                end
                $display("txn b2b i=%0d", i - 1);
            end
            if (i < 4) begin
                in_valid = 1'b1; M_control = 2'b00; WB_control_in = 2'b10;
                alu_result = a[i]; dest_in = d[i];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_misalign();
`ifdef MEM_ALIGN_CHECK_EN
        do_txn(2'b10, 2'b11, 32'h42, 32'h0, 5'd8, 1, 32'h0);
`else
        do_txn(2'b10, 2'b11, 32'h42, 32'h0, 5'd8, 2, 32'hA5A5A5A5);
`endif
    endtask

    task automatic test_random();
        logic [1:0]  mc;
        logic [31:0] addr;
        int lat;
        for (int i = 0; i < 40; i++) begin
            mc   = 2'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            lat  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO + 3);
            do_txn(mc, 2'($urandom), addr, $urandom, 5'($urandom), lat, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        test_misalign();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
